// File: rtl/periph_bus_master.sv
// periph_bus_master
// Bus initiator that turns CPU load/store requests into peripheral bus
// transactions: word-addressed bus, byte-lane write enables, and one-cycle
// registered read data from the responder.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only while IDLE)
//   req_we                  1 = store, 0 = load
//   req_addr                byte address
//   req_size                0 = byte, 1 = half, 2 = word, 3 = reserved
//   req_unsigned            loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata               store data, right-aligned
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata               load result (0 for stores and faults)
//   rsp_fault               access fault, qualified by rsp_valid
//   bus_ce                  one-hot device select from req_addr[19:18]
//   bus_we                  byte-lane write enables
//   bus_re                  read enable
//   bus_addr                word address, req_addr[17:2]
//   bus_wdata               lane-aligned write data
//   bus_rdata               responder read data
module periph_bus_master #(
  parameter logic [11:0] PERIPH_BASE = 12'h100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [3:0]  bus_ce,
  output logic [3:0]  bus_we,
  output logic        bus_re,
  output logic [15:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {IDLE, WR, RD0, RD1, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_fault_q, rsp_fault_d;
  logic [3:0]  bus_ce_q, bus_ce_d;
  logic [3:0]  bus_we_q, bus_we_d;
  logic        bus_re_q, bus_re_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic        fault;
  logic [3:0]  dev_sel;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;
  logic [31:0] rd_shifted;
  logic [31:0] load_data;

  // Request decode: fault detection, device select and store lane placement
  // are all computed straight from the request so the bus registers can be
  // loaded on the acceptance edge itself.
  always_comb begin
    fault = (req_addr[31:20] != PERIPH_BASE) ||
            (req_size == 2'd3) ||
            (req_size == 2'd1 && req_addr[0]) ||
            (req_size == 2'd2 && req_addr[1:0] != 2'b00);
    dev_sel    = 4'b0001 << req_addr[19:18];
    lane_we    = 4'b0000;
    lane_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        lane_we    = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        lane_we    = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        lane_we    = 4'b1111;
        lane_wdata = req_wdata;
      end
      default: begin
        lane_we    = 4'b0000;
        lane_wdata = req_wdata;
      end
    endcase
  end

  // Load extraction uses the lane/size/sign captured at acceptance, since the
  // request inputs are no longer meaningful by the time RD1 samples the bus.
  always_comb begin
    rd_shifted = bus_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    load_data = unsigned_q ? {24'h0, rd_shifted[7:0]}
                                      : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1:    load_data = unsigned_q ? {16'h0, rd_shifted[15:0]}
                                      : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_data = bus_rdata;
    endcase
  end

  // Next-state and registered-output logic. Every output is a flop whose next
  // value is chosen for the state being entered, so the bus strobes appear in
  // exactly the cycle the FSM occupies WR/RD0/RD1.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_fault_d = 1'b0;
    bus_ce_d    = 4'b0000;
    bus_we_d    = 4'b0000;
    bus_re_d    = 1'b0;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          lane_d     = req_addr[1:0];
          size_d     = req_size;
          unsigned_d = req_unsigned;
          if (fault) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
          end else if (req_we) begin
            state_d     = WR;
            bus_ce_d    = dev_sel;
            bus_we_d    = lane_we;
            bus_addr_d  = req_addr[17:2];
            bus_wdata_d = lane_wdata;
          end else begin
            state_d    = RD0;
            bus_ce_d   = dev_sel;
            bus_re_d   = 1'b1;
            bus_addr_d = req_addr[17:2];
          end
        end
      end
      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RD0: begin
        // Strobes held so the responder's registered read stays selected.
        state_d  = RD1;
        bus_ce_d = bus_ce_q;
        bus_re_d = 1'b1;
      end
      RD1: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_data;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lane_q      <= 2'b00;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_fault_q <= 1'b0;
      bus_ce_q    <= 4'b0000;
      bus_we_q    <= 4'b0000;
      bus_re_q    <= 1'b0;
      bus_addr_q  <= 16'h0;
      bus_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
      bus_ce_q    <= bus_ce_d;
      bus_we_q    <= bus_we_d;
      bus_re_q    <= bus_re_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;
  assign bus_ce    = bus_ce_q;
  assign bus_we    = bus_we_q;
  assign bus_re    = bus_re_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: doc/periph_bus_master.md
# periph_bus_master

Bus initiator that turns CPU load/store requests into transactions on the peripheral bus: word-addressed, with byte-lane write enables and one-cycle registered read data. It sits between the load/store path and the peripheral responders (GPIO and siblings). It decodes the peripheral region into one-hot chip enables, places write data on the correct lanes, and holds read strobes for the responder's registered read. It then extracts, sign-extends or zero-extends, and returns load data.

## Interface
- PERIPH_BASE, 12'h100: value of req_addr[31:20] that selects the peripheral region.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result; 0 for stores and faults.
- rsp_fault  out  1  access fault; valid with rsp_valid.
- bus_ce  out  4  one-hot device select; index is req_addr[19:18].
- bus_we  out  4  byte-lane write enables.
- bus_re  out  1  read enable.
- bus_addr  out  16  word address, req_addr[17:2].
- bus_wdata  out  32  lane-aligned write data.
- bus_rdata  in  32  responder read data; high-Z when no responder is selected.

## Operation
- FSM states: IDLE, WR, RD0, RD1, RESP.
- Acceptance happens at the edge where req_valid && req_ready. Address, size, unsigned flag and data are latched at that edge.
- Fault conditions: req_addr[31:20] != PERIPH_BASE; size 3; half with addr[0]=1; word with addr[1:0] != 0.
- On a fault: IDLE goes to RESP. No bus activity. rsp_fault=1 and rsp_rdata=0.
- Store: IDLE → WR → RESP. In WR, bus_ce is the one-hot device select and bus_we is set as follows:
  - Byte: we = 1 << addr[1:0]; wdata = byte replicated ×4.
  - Half: we = addr[1] ? 4'b1100 : 4'b0011; wdata = half replicated ×2.
  - Word: we = 4'b1111; wdata = req_wdata.
- Load: IDLE → RD0 → RD1 → RESP.
  - bus_ce, bus_re and bus_addr are held constant across RD0 and RD1.
  - The responder registers data at the end of RD0.
  - The master samples bus_rdata at the end of RD1.
- Load extraction:
  - Byte: lane addr[1:0].
  - Half: addr[1] ? [31:16] : [15:0].
  - Word: all 32 bits.
  - Narrow results are extended according to req_unsigned.
- RESP always returns to IDLE.
- bus_ce, bus_we and bus_re are 0 in every state except those listed above. bus_addr and bus_wdata hold their last driven value.
- bus_we and bus_re are never both nonzero. At most one bus_ce bit is set.

## Timing
- All outputs are registered.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, bus_ce=0, bus_we=0, bus_re=0, bus_addr=0, bus_wdata=0.
- Latency from the acceptance edge to rsp_valid: fault 1 cycle, store 2 cycles, load 3 cycles.
- req_ready is low from the cycle after acceptance through RESP. The next request can be accepted at the first edge after returning to IDLE.
- rsp_valid is high for exactly one cycle and has no backpressure. rsp_rdata and rsp_fault are valid only while rsp_valid=1.
- req_valid is ignored in every state except IDLE; there is no queueing.
- bus_rdata is sampled only at the end of RD1. Its value in any other cycle, including Z/X, has no effect.
- Asserting rst_n low in any state immediately clears all outputs to their reset values and returns to IDLE. The in-flight request is dropped and no rsp_valid is issued.

## Test plan
- Reset: hold rst_n=0, then release → all outputs at reset values; req_ready=1; no bus strobes for 10 idle cycles.
- Word store to 0x1000_0000 with data 0xA5A5_1234 → WR cycle shows ce=0001, we=1111, addr=0x0000, wdata=0xA5A5_1234. rsp_valid comes 2 cycles after acceptance with fault=0.
- Byte store to 0x1000_0006 with data 0x5A → ce=0001, addr=0x0001, we=0100, wdata=0x5A5A_5A5A. Half store to 0x1004_0002 with 0xBEEF → ce=0010, we=1100, wdata=0xBEEF_BEEF.
- Loads from a registered responder model that returns 0x80C0_7F01:
  - Signed byte at 0x1000_0003 → 0xFFFF_FF80.
  - Unsigned byte at the same address → 0x0000_0080.
  - Signed half at 0x1000_0000 → 0x0000_7F01.
  - In each case re and ce are stable over RD0/RD1 and rsp_valid comes 3 cycles after acceptance.
- Faults: half at 0x1000_0001, word at 0x2000_0000, size 3 at 0x1000_0000 → rsp_valid 1 cycle after acceptance, rsp_fault=1, rsp_rdata=0, bus_ce/we/re remain 0.
- Reset mid-operation: pull rst_n low during RD0 → ce and re drop immediately; no rsp_valid. After release, a word load completes normally.
